tlm_mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port 32-bit memory between NUM_REQ transaction requesters.
- Requesters are TLM-target front ends carrying generic-payload read and write commands.
- The memory registers its address; q is valid the cycle after the address is sampled.
- The block accepts one request at a time and drives the memory's addr/data/we pins. Partial-byte-enable writes are done as read-modify-write, and a one-cycle response with status goes back to the granted requester.

---
 rtl/tlm_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tlm_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlm_mem_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-address 32-bit memory between
// NUM_REQ requesters; partial-byte writes are done as read-modify-write.
module tlm_mem_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_write_i,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ*4-1:0]  req_be_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic [1:0]            rsp_status_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic                  mem_we_o,
    input  logic [31:0]           mem_q_i
);

    typedef enum logic [2:0] {StIdle, StRdIssue, StRdData, StWr, StResp} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       status_q, status_d;

    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    int unsigned      cand;
    logic             sel_write;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_be;
    logic [31:0]      merged;

    // First valid requester searching upward from ptr+1, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr_q) + i) % NUM_REQ;
            if (!gnt_any && req_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(cand);
            end
        end
    end

    always_comb begin
        sel_write = req_write_i[gnt_idx];
        sel_addr  = req_addr_i[32*gnt_idx +: 32];
        sel_wdata = req_wdata_i[32*gnt_idx +: 32];
        sel_be    = req_be_i[4*gnt_idx +: 4];
    end

    always_comb begin
        merged = '0;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : mem_q_i[8*b +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        data_d   = data_q;
        status_d = status_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    ptr_d    = gnt_idx;
                    idx_d    = gnt_idx;
                    write_d  = sel_write;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    be_d     = sel_be;
                    data_d   = '0;
                    status_d = 2'd0;
                    if (sel_addr >= DEPTH) begin
                        status_d = 2'd1;
                        state_d  = StResp;
                    end else if (!sel_write) begin
                        state_d = StRdIssue;
                    end else if (sel_be == 4'hF) begin
                        data_d  = sel_wdata;
                        state_d = StWr;
                    end else if (sel_be == 4'h0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StRdIssue;
                    end
                end
            end
            StRdIssue: state_d = StRdData;
            StRdData: begin
                data_d  = write_q ? merged : mem_q_i;
                state_d = write_q ? StWr : StResp;
            end
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            idx_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    // Memory pins come only from registered state, never from req_* inputs.
    always_comb begin
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_rdata_o  = '0;
        rsp_status_o = '0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_we_o     = 1'b0;
        if (state_q == StIdle && gnt_any) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
        if (state_q == StRdIssue || state_q == StRdData || state_q == StWr) begin
            mem_addr_o = addr_q;
        end
        if (state_q == StWr) begin
            mem_we_o   = 1'b1;
            mem_data_o = data_q;
        end
        if (state_q == StResp) begin
            rsp_valid_o[idx_q] = 1'b1;
            rsp_rdata_o        = data_q;
            rsp_status_o       = status_q;
        end
    end

endmodule

// File: tb/tb_tlm_mem_arbiter.sv
// Bench for tlm_mem_arbiter: table of single transactions checked through a response
// scoreboard, plus hand-written reset, fairness and mid-operation reset sequences.
module tb_tlm_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  valid = '0;
    logic [1:0]  ready;
    logic [1:0]  wr = '0;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  be = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_q;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int we_count = 0;
    int last_we_cyc = -1;
    logic [31:0] last_we_addr = '0;

    tlm_mem_arbiter #(.NUM_REQ(2), .DEPTH(256)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (valid),
        .req_ready_o  (ready),
        .req_write_i  (wr),
        .req_addr_i   (addr),
        .req_wdata_i  (wdata),
        .req_be_i     (be),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_status_o (rsp_status),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data),
        .mem_we_o     (mem_we),
        .mem_q_i      (mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory model: registered address, q valid the cycle after the address is sampled.
    logic [31:0] ram [0:255];
    logic [31:0] maddr_q = '0;
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_we && mem_addr < 32'd256) ram[mem_addr[7:0]] <= mem_data;
        maddr_q <= mem_addr;
    end
    assign mem_q = (maddr_q < 32'd256) ? ram[maddr_q[7:0]] : 32'h0;

    typedef struct {
        int          req;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [1:0]  status;
        int          lat;
        int          we_off;
        logic [31:0] ram_after;
    } vec_t;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic [1:0]  status;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%b required=00", rsp_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_onehot", 32'(rsp_valid), 32'(1 << e.req));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_status", 32'(rsp_status), 32'(e.status));
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
        if (mem_we === 1'b1) begin
            we_count++;
            last_we_cyc  = cyc;
            last_we_addr = mem_addr;
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        #2;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({nm, "_rsp_pending"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        int n = 0;
        int acc;
        int we0;
        @(negedge clk);
        valid            = '0;
        valid[v.req]     = 1'b1;
        wr[v.req]        = v.write;
        addr[32*v.req +: 32]  = v.addr;
        wdata[32*v.req +: 32] = v.wdata;
        be[4*v.req +: 4] = v.be;
        we0 = we_count;
        #1;
        while (ready[v.req] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_grant"}, 32'(ready), 32'(1 << v.req));
        if (ready[v.req] !== 1'b1) begin
            valid = '0;
            return;
        end
        acc = cyc;
        sb.push_back('{v.req, v.rdata, v.status, acc + v.lat});
        @(negedge clk);
        valid = '0;
        drain(nm);
        chk({nm, "_we_count"}, we_count - we0, (v.we_off != 0) ? 1 : 0);
        if (v.we_off != 0) begin
            chk({nm, "_we_cycle"}, last_we_cyc, acc + v.we_off);
            chk({nm, "_we_addr"}, last_we_addr, v.addr);
        end
        if (v.addr < 32'd256) chk({nm, "_ram"}, ram[v.addr[7:0]], v.ram_after);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_g;
        int acc;
        int we0;

        vt[0] = '{0, 1'b0, 32'd5,   32'h0,        4'h0, 32'hAA000012, 2'd0, 3, 0, 32'hAA000012};
        vt[1] = '{1, 1'b1, 32'd7,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2'd0, 2, 1, 32'hDEADBEEF};
        vt[2] = '{0, 1'b0, 32'd7,   32'h0,        4'h0, 32'hDEADBEEF, 2'd0, 3, 0, 32'hDEADBEEF};
        vt[3] = '{1, 1'b1, 32'd9,   32'hAABBCCDD, 4'h5, 32'h11BB33DD, 2'd0, 4, 3, 32'h11BB33DD};
        vt[4] = '{0, 1'b1, 32'd256, 32'hCAFEF00D, 4'hF, 32'h0,        2'd1, 1, 0, 32'h0};
        vt[5] = '{1, 1'b1, 32'd10,  32'h12345678, 4'h0, 32'h0,        2'd0, 1, 0, 32'h0};
        vt[6] = '{0, 1'b0, 32'd300, 32'h0,        4'h0, 32'h0,        2'd1, 1, 0, 32'h0};
        vt[7] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h1, 4'hF, 32'h0,        2'd1, 1, 0, 32'h0};
        vt[8] = '{0, 1'b1, 32'd12,  32'h77665544, 4'h8, 32'h77020304, 2'd0, 4, 3, 32'h77020304};
        vt[9] = '{1, 1'b0, 32'd255, 32'h0,        4'h0, 32'h0BADF00D, 2'd0, 3, 0, 32'h0BADF00D};

        preload(8'd5,   32'hAA000012);
        preload(8'd7,   32'h0);
        preload(8'd9,   32'h11223344);
        preload(8'd10,  32'h0);
        preload(8'd12,  32'h01020304);
        preload(8'd20,  32'h55667788);
        preload(8'd255, 32'h0BADF00D);

        // Reset, idle, then priority after reset goes to requester 0.
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_outputs", {ready, rsp_valid, rsp_status, mem_we, 25'd0},
            32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        valid = 2'b01;
        #1 chk("rst_ready_01", 32'(ready), 32'h1);
        valid = 2'b11;
        #1 chk("rst_ready_11", 32'(ready), 32'h1);
        valid = 2'b00;

        for (int i = 0; i < 10; i++) do_txn(vt[i], $sformatf("vec%0d", i));

        // Fairness: both requesters hold valid with reads; grants alternate from 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        wr    = 2'b00;
        addr  = {32'd7, 32'd5};
        be    = 8'h00;
        valid = 2'b11;
        exp_g = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            #1;
            while (ready === 2'b00 && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk($sformatf("fair_grant%0d", g), 32'(ready), 32'(1 << exp_g));
            sb.push_back('{exp_g, (exp_g == 1) ? 32'hDEADBEEF : 32'hAA000012, 2'd0, cyc + 3});
            exp_g ^= 1;
            @(negedge clk);
        end
        valid = 2'b00;
        drain("fair");

        // Reset during RD_DATA of a partial write: no write, no response, ptr restored.
        @(negedge clk);
        wr[0]         = 1'b1;
        addr[31:0]    = 32'd20;
        wdata[31:0]   = 32'hAAAABBBB;
        be[3:0]       = 4'h3;
        valid         = 2'b01;
        we0           = we_count;
        #1 chk("mid_grant", 32'(ready), 32'h1);
        acc = cyc;
        @(negedge clk);
        valid = 2'b00;
        @(negedge clk);
        chk("mid_rd_data_cycle", cyc, acc + 2);
        chk("mid_mem_addr", mem_addr, 32'd20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_we_after_rst", 32'(mem_we), 32'd0);
        chk("mid_rsp_after_rst", 32'(rsp_valid), 32'd0);
        repeat (4) @(negedge clk);
        chk("mid_we_count", we_count - we0, 0);
        chk("mid_ram", ram[20], 32'h55667788);
        valid = 2'b11;
        #1 chk("mid_next_grant", 32'(ready), 32'h1);
        valid = 2'b00;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
